// File: rtl/fetch_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_mem_unit
// Purpose  : Program counter, instruction register (IR) and memory data
//            register (MDR) of a multi-cycle RISC-V core. Executes the control
//            unit's per-state memory and PC-write strobes against a
//            variable-latency req/ready memory and stalls the control unit
//            until each access has completed.
// Ports    : clk, reset               - clock, synchronous active-high reset
//            mem_read/mem_write       - access strobes from control
//            i_or_d                   - 0: address = pc, 1: address = alu_out
//            IR_write                 - completed instruction read loads IR
//            PC_write                 - unconditional PC update
//            PC_write_not_cond        - PC update gated by alu_bcond
//            PC_source                - next PC: 0 alu_result, 1 alu_out
//            alu_result/alu_out       - ALU combinational/registered result
//            alu_bcond, store_data    - branch condition, store data
//            mem_req/we/addr/wdata    - registered memory request
//            mem_rdata/mem_ready      - memory response
//            stall                    - control unit must hold its state
//            pc, inst, part_of_inst   - PC, IR, IR opcode field
//            mdr                      - last data-read result
// Revision : 1.0 - initial release
// ============================================================================
module fetch_mem_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        i_or_d,
    input  logic        IR_write,
    input  logic        PC_write,
    input  logic        PC_write_not_cond,
    input  logic        PC_source,
    input  logic [31:0] alu_result,
    input  logic [31:0] alu_out,
    input  logic        alu_bcond,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic [6:0]  part_of_inst,
    output logic [31:0] mdr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUSY     = 2'd1,
        ST_COMPLETE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] mdr_q, mdr_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    // Attributes of the access in flight, captured with the request so the
    // response is routed by what was asked for, not by later strobe values.
    logic        acc_read_q, acc_read_d;
    logic        acc_data_q, acc_data_d;
    logic        acc_irw_q, acc_irw_d;

    logic        access_req;
    logic        stall_w;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        inst_d      = inst_q;
        mdr_d       = mdr_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        acc_read_d  = acc_read_q;
        acc_data_d  = acc_data_q;
        acc_irw_d   = acc_irw_q;

        access_req = mem_read | mem_write;

        // Stall covers the request cycle and every BUSY cycle; COMPLETE is the
        // cycle in which the control unit is allowed to advance.
        stall_w = 1'b0;
        if (state_q == ST_BUSY) begin
            stall_w = 1'b1;
        end else if (state_q == ST_IDLE && access_req) begin
            stall_w = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (access_req) begin
                    mem_addr_d  = i_or_d ? alu_out : pc_q;
                    // A simultaneous read and write is treated as a read.
                    mem_we_d    = mem_write & ~mem_read;
                    mem_wdata_d = store_data;
                    mem_req_d   = 1'b1;
                    acc_read_d  = mem_read;
                    acc_data_d  = i_or_d;
                    acc_irw_d   = IR_write;
                    state_d     = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_COMPLETE;
                    if (acc_read_q) begin
                        if (acc_data_q) begin
                            mdr_d = mem_rdata;
                        end else if (acc_irw_q) begin
                            inst_d = mem_rdata;
                        end
                    end
                end
            end
            ST_COMPLETE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        // PC only moves in a non-stalled cycle, so an instruction address is
        // never changed underneath an access being issued.
        if (!stall_w && (PC_write || (PC_write_not_cond && alu_bcond))) begin
            pc_d = PC_source ? alu_out : alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pc_q        <= RESET_PC;
            inst_q      <= 32'h0;
            mdr_q       <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_wdata_q <= 32'h0;
            acc_read_q  <= 1'b0;
            acc_data_q  <= 1'b0;
            acc_irw_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            mdr_q       <= mdr_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            acc_read_q  <= acc_read_d;
            acc_data_q  <= acc_data_d;
            acc_irw_q   <= acc_irw_d;
        end
    end

    assign mem_req      = mem_req_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign stall        = stall_w;
    assign pc           = pc_q;
    assign inst         = inst_q;
    assign part_of_inst = inst_q[6:0];
    assign mdr          = mdr_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_mem_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_mem_unit
// Purpose  : Self-checking bench for fetch_mem_unit. Directed accesses and
//            branches followed by randomized ones, checked against a
//            transaction-level model of PC / IR / MDR and of the per-cycle
//            stall and request behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_mem_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, i_or_d, IR_write;
    logic        PC_write, PC_write_not_cond, PC_source;
    logic [31:0] alu_result, alu_out, store_data;
    logic        alu_bcond;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;
    logic        stall;
    logic [31:0] pc, inst, mdr;
    logic [6:0]  part_of_inst;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: what the architectural registers should hold.
    logic [31:0] m_pc, m_ir, m_mdr;

    fetch_mem_unit #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .i_or_d            (i_or_d),
        .IR_write          (IR_write),
        .PC_write          (PC_write),
        .PC_write_not_cond (PC_write_not_cond),
        .PC_source         (PC_source),
        .alu_result        (alu_result),
        .alu_out           (alu_out),
        .alu_bcond         (alu_bcond),
        .store_data        (store_data),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_rdata         (mem_rdata),
        .mem_ready         (mem_ready),
        .stall             (stall),
        .pc                (pc),
        .inst              (inst),
        .part_of_inst      (part_of_inst),
        .mdr               (mdr)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        mem_read          = 1'b0;
        mem_write         = 1'b0;
        i_or_d            = 1'b0;
        IR_write          = 1'b0;
        PC_write          = 1'b0;
        PC_write_not_cond = 1'b0;
        PC_source         = 1'b0;
        alu_bcond         = 1'b0;
        mem_ready         = 1'b0;
    endtask

    // One complete memory access: request cycle, lat BUSY cycles (ready on the
    // last), one COMPLETE cycle. PC_write (if used) is held through the whole
    // access, as a control unit would while stalled; it may only act in
    // COMPLETE.
    task automatic access(input bit rd, input bit wr, input bit iod, input bit irw,
                          input bit pcw, input bit psrc,
                          input logic [31:0] aout, input logic [31:0] sdata,
                          input logic [31:0] rdata, input logic [31:0] ares,
                          input int lat, input string tag);
        logic [31:0] exp_addr;
        logic        exp_we;
        exp_addr = iod ? aout : m_pc;
        exp_we   = wr & ~rd;
        mem_read = rd; mem_write = wr; i_or_d = iod; IR_write = irw;
        PC_write = pcw; PC_source = psrc; alu_out = aout; alu_result = ares;
        store_data = sdata;
        #1;
        chk({tag, " idle stall"}, 32'(stall), 32'd1);
        chk({tag, " idle req"}, 32'(mem_req), 32'd0);
        tick();
        for (int k = 1; k <= lat; k++) begin
            mem_ready = (k == lat);
            mem_rdata = (k == lat) ? rdata : $urandom;
            #1;
            chk({tag, " busy stall"}, 32'(stall), 32'd1);
            chk({tag, " busy req"}, 32'(mem_req), 32'd1);
            chk({tag, " busy we"}, 32'(mem_we), 32'(exp_we));
            chk({tag, " busy addr"}, mem_addr, exp_addr);
            chk({tag, " busy wdata"}, mem_wdata, sdata);
            chk({tag, " busy pc"}, pc, m_pc);
            tick();
        end
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        #1;
        if (rd) begin
            if (iod) m_mdr = rdata;
            else if (irw) m_ir = rdata;
        end
        chk({tag, " complete stall"}, 32'(stall), 32'd0);
        chk({tag, " complete req"}, 32'(mem_req), 32'd0);
        chk({tag, " inst"}, inst, m_ir);
        chk({tag, " part_of_inst"}, 32'(part_of_inst), 32'(m_ir[6:0]));
        chk({tag, " mdr"}, mdr, m_mdr);
        if (pcw) m_pc = psrc ? aout : ares;
        tick();
        clear_strobes();
        #1;
        chk({tag, " pc after"}, pc, m_pc);
    endtask

    // Single non-memory cycle with PC strobes (e.g. a branch state).
    task automatic pc_cycle(input bit pw, input bit pwnc, input bit bc, input bit psrc,
                            input logic [31:0] aout, input logic [31:0] ares,
                            input string tag);
        PC_write = pw; PC_write_not_cond = pwnc; alu_bcond = bc; PC_source = psrc;
        alu_out = aout; alu_result = ares;
        #1;
        chk({tag, " stall"}, 32'(stall), 32'd0);
        if (pw || (pwnc && bc)) m_pc = psrc ? aout : ares;
        tick();
        clear_strobes();
        #1;
        chk({tag, " pc"}, pc, m_pc);
    endtask

    initial begin
        bit rd, wr, iod, irw, pcw, psrc;
        clear_strobes();
        reset = 1'b1;
        alu_result = '0; alu_out = '0; store_data = '0; mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
        m_pc = RESET_PC; m_ir = '0; m_mdr = '0;
        #1;
        chk("reset pc", pc, RESET_PC);
        chk("reset inst", inst, 32'h0);
        chk("reset mdr", mdr, 32'h0);
        chk("reset req", 32'(mem_req), 32'd0);
        chk("reset we", 32'(mem_we), 32'd0);
        chk("reset addr", mem_addr, 32'h0);
        chk("reset wdata", mem_wdata, 32'h0);
        chk("reset stall", 32'(stall), 32'd0);

        // Instruction fetch, zero-wait memory, PC+4 written in COMPLETE.
        access(1, 0, 0, 1, 1, 0, 32'h0, 32'h0, 32'h0050_0093, 32'h4, 1, "fetch");
        chk("fetch opcode", 32'(part_of_inst), 32'h13);
        chk("fetch pc", pc, 32'h4);

        // Load, three BUSY cycles.
        access(1, 0, 1, 0, 0, 0, 32'h100, 32'h0, 32'hDEAD_BEEF, 32'h0, 3, "load");
        chk("load mdr", mdr, 32'hDEAD_BEEF);

        // Store, two BUSY cycles; MDR must not move.
        access(0, 1, 1, 0, 0, 0, 32'h200, 32'h1234, 32'h5555_AAAA, 32'h0, 2, "store");

        // Branch not taken then taken.
        pc_cycle(0, 1, 0, 1, 32'h40, 32'h0, "branch nt");
        pc_cycle(0, 1, 1, 1, 32'h40, 32'h0, "branch t");
        chk("branch target", pc, 32'h40);

        // Read and write together: a read with mem_we low.
        access(1, 1, 1, 0, 0, 0, 32'h300, 32'h9999, 32'hCAFE_F00D, 32'h0, 1, "rdwr");

        // Ready pulse while idle: no effect.
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("idle ready stall", 32'(stall), 32'd0);
        tick();
        mem_ready = 1'b0;
        #1;
        chk("idle ready req", 32'(mem_req), 32'd0);
        chk("idle ready inst", inst, m_ir);
        chk("idle ready mdr", mdr, m_mdr);

        // Randomized accesses and PC cycles.
        for (int i = 0; i < 30; i++) begin
            rd = 1'($urandom); wr = 1'($urandom);
            if (!rd && !wr) rd = 1'b1;
            iod = 1'($urandom); irw = 1'($urandom);
            pcw = 1'($urandom); psrc = 1'($urandom);
            access(rd, wr, iod, irw, pcw, psrc, $urandom, $urandom, $urandom, $urandom,
                   int'($urandom_range(1, 4)), "rand acc");
            pc_cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     $urandom, $urandom, "rand pc");
        end

        // Reset in the second BUSY cycle of a fetch, late ready afterwards.
        mem_read = 1'b1; i_or_d = 1'b0; IR_write = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_strobes();
        m_pc = RESET_PC; m_ir = '0; m_mdr = '0;
        #1;
        chk("midreset req", 32'(mem_req), 32'd0);
        chk("midreset pc", pc, RESET_PC);
        chk("midreset inst", inst, 32'h0);
        mem_ready = 1'b1;
        mem_rdata = 32'h1234_5678;
        tick();
        mem_ready = 1'b0;
        #1;
        chk("late ready inst", inst, 32'h0);
        chk("late ready mdr", mdr, 32'h0);
        chk("late ready req", 32'(mem_req), 32'd0);
        chk("late ready stall", 32'(stall), 32'd0);
        chk("late ready pc", pc, m_pc);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
